sevenseg_scan5: RTL
===================

# sevenseg_scan5

Time-multiplexed driver for a 5-digit common-anode seven-segment display, consuming the five BCD digits produced by the 16-bit binary-to-BCD converter. It buffers a new value on a load strobe, commits it only at a frame boundary so no frame shows mixed digits, and scans the digits round-robin with optional leading-zero blanking. It sits between the BCD conversion of the CPU debug/output value and the board display pins.

## Interface

- REFRESH_DIV, 50000, clock cycles each digit is lit; legal range ≥ 2.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- bcd4..bcd0  in  4 each  digit values; bcd4 is 10⁴'s, bcd0 is 10⁰'s.
- load  in  1  capture bcd4..bcd0 into the shadow register this cycle.
- blank_lz  in  1  1 = blank leading zero digits.
- enable  in  1  0 = all anodes off; the scan keeps running.
- an  out  5  anode enables, active-low; an[k] lights digit k.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  out  1  one-cycle pulse on each frame wrap.

## Operation

- Divider div_cnt counts 0..REFRESH_DIV-1 and wraps. Terminal count (TC) = div_cnt==REFRESH_DIV-1.
- Digit index idx is 0..4. At TC, idx increments; idx 4 wraps to 0. One frame = 5·REFRESH_DIV cycles.
- Shadow register: load=1 captures bcd4..bcd0 and sets pending=1. A later load overwrites the shadow. The last load before commit wins.
- Commit: at TC with idx==4 (frame wrap), if pending=1, the display register is loaded from the shadow and pending clears. The commit uses the shadow contents from before that edge. A load in the same cycle updates the shadow and sets pending, so it commits at the next frame wrap.
- frame_done is registered. It is 1 for exactly the one cycle after each frame-wrap edge.
- Leading-zero blanking, computed from the display register:
  - Digit k (k = 4..1) is blanked when blank_lz=1 and display digits k..4 are all 0.
  - Digit 0 is never blanked.
- Segment decode, active-low:
  - 0 → 7'h40, 1 → 7'h79, 2 → 7'h24, 3 → 7'h30, 4 → 7'h19
  - 5 → 7'h12, 6 → 7'h02, 7 → 7'h78, 8 → 7'h00, 9 → 7'h10
  - 10–15 → 7'h3F (dash, g only)
  - blanked → 7'h7F
- Output registers, sampled every cycle from the current idx and display register:
  - an = ~(5'b00001 << idx) when enable=1, else 5'b11111.
  - seg = decode of the display digit selected by idx. seg is 7'h7F when enable=0 or the digit is blanked.
- Blanked digits keep their scan slot. The anode is still driven low with seg=7'h7F, which keeps brightness uniform.

## Timing

- Reset values: div_cnt=0, idx=0, pending=0, shadow=0, display=0, an=5'b11111, seg=7'h7F, frame_done=0.
- First rising edge after reset release with enable=1: an=5'b11110, seg=7'h40 (digit 0 shows "0").
- an/seg lag idx by one cycle. Each digit's lit window is exactly REFRESH_DIV cycles, shifted by one cycle relative to idx.
- Load-to-display latency:
  - Minimum: 1 cycle plus the wait to the next frame wrap.
  - Maximum: 5·REFRESH_DIV cycles, plus one cycle for the an/seg register.
- enable changes take effect on an/seg at the next edge. Divider, idx, shadow and commit are unaffected by enable.
- Reset asserted mid-frame forces all reset values immediately, asynchronously. Pending data is discarded.
- blank_lz is combinational into the seg register, so changes apply at the next edge.

## Test plan

- Reset/first digit (REFRESH_DIV=4, enable=1): release reset → next edge an=11110, seg=7'h40. Then an=11101 after 4 cycles, cycling back to 11110 after 20 cycles; frame_done pulses every 20 cycles.
- Load 1,2,3,4,5 (bcd4..bcd0) mid-frame → display unchanged until the frame-wrap edge. In the next frame, digit 0 shows 7'h12, digit1 7'h19, digit2 7'h30, digit3 7'h24, digit4 7'h79.
- Load on the frame-wrap cycle, and a double load within one frame: the same-cycle load commits one frame later; with two loads in a frame, only the second value appears.
- Leading zero (blank_lz=1, value 0,0,4,0,7): digits 4,3 → seg 7'h7F with anode low; digit2 → 7'h19, digit1 → 7'h40, digit0 → 7'h78. Value 00000 shows only digit0 = 7'h40.
- Invalid BCD 4'hB on digit2 → seg 7'h3F in slot 2; enable=0 for one frame → an=11111, seg=7'h7F throughout while frame_done still pulses.
- Reset asserted mid-frame with pending=1 → outputs go to reset values without a clock edge. After release the display shows 0s and the discarded value never appears.

Source files
------------

// File: rtl/sevenseg_scan5.sv
// sevenseg_scan5: 5-digit multiplexed seven-segment driver with frame-aligned commit
// and leading-zero blanking; an/seg are registered and lag the scan index by one cycle.
module sevenseg_scan5 #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bcd4,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic       load,
    input  logic       blank_lz,
    input  logic       enable,
    output logic [4:0] an,
    output logic [6:0] seg,
    output logic       frame_done
);
    localparam int DW = $clog2(REFRESH_DIV);

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    idx_q, idx_d;
    logic [19:0]   shadow_q, shadow_d, disp_q, disp_d;
    logic          pending_q, pending_d;
    logic [4:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          fd_q, fd_d;
    logic          tc, wrap, blank;
    logic [3:0]    dig [5];
    logic [3:0]    cur;
    logic [4:0]    zero;

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0:    dec = 7'h40;
            4'd1:    dec = 7'h79;
            4'd2:    dec = 7'h24;
            4'd3:    dec = 7'h30;
            4'd4:    dec = 7'h19;
            4'd5:    dec = 7'h12;
            4'd6:    dec = 7'h02;
            4'd7:    dec = 7'h78;
            4'd8:    dec = 7'h00;
            4'd9:    dec = 7'h10;
            default: dec = 7'h3F;
        endcase
    endfunction

    always_comb begin
        tc        = div_q == DW'(REFRESH_DIV - 1);
        wrap      = tc && idx_q == 3'd4;
        div_d     = tc ? '0 : div_q + DW'(1);
        idx_d     = tc ? (idx_q == 3'd4 ? 3'd0 : idx_q + 3'd1) : idx_q;
        shadow_d  = load ? {bcd4, bcd3, bcd2, bcd1, bcd0} : shadow_q;
        // commit uses the pre-edge shadow; a same-cycle load stays pending for the next frame
        disp_d    = (wrap && pending_q) ? shadow_q : disp_q;
        pending_d = load || (pending_q && !wrap);
        for (int k = 0; k < 5; k++) dig[k] = disp_q[4*k +: 4];
        zero[4] = dig[4] == 4'd0;
        for (int k = 3; k >= 0; k--) zero[k] = zero[k+1] && dig[k] == 4'd0;
        cur   = dig[idx_q];
        blank = blank_lz && idx_q != 3'd0 && zero[idx_q];
        an_d  = enable ? ~(5'b00001 << idx_q) : 5'b11111;
        seg_d = (!enable || blank) ? 7'h7F : dec(cur);
        fd_d  = wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            an_q      <= 5'b11111;
            seg_q     <= 7'h7F;
            fd_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            fd_q      <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;
endmodule
